pic_frame_loader: RTL and testbench

- Upstream image source for the VGA display stage.
- Receives a 220x180 RGB332 picture as a byte stream with a valid/ready handshake and stores it in an internal single-port-write / single-port-read RAM.
- Serves pixels to the display stage through an address/data read port with 1-cycle registered latency, so it can be dropped in where the picture ROM sat.

---
 rtl/pic_frame_loader_if.sv | 23 ++
 rtl/pic_frame_loader.sv | 97 +++++++++
 tb/tb_pic_frame_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pic_frame_loader_if.sv
// Byte-stream write port and pixel read port shared by the picture source,
// the frame loader and the display stage.
interface pic_frame_loader_if #(
    parameter int AW = 16,
    parameter int DW = 8
) ();
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    modport master (
        output in_data, in_valid, in_sof, rd_addr,
        input  in_ready, rd_data
    );

    modport slave (
        input  in_data, in_valid, in_sof, rd_addr,
        output in_ready, rd_data
    );
endinterface

// File: rtl/pic_frame_loader.sv
// Loads an RGB332 picture from a valid/ready byte stream into internal RAM and
// serves it to the display stage through a 1-cycle registered read port.
module pic_frame_loader #(
    parameter int            PIX_W   = 220,
    parameter int            PIX_H   = 180,
    parameter int            PIX_NUM = PIX_W * PIX_H,
    parameter int            AW      = 16,
    parameter int            DW      = 8,
    parameter logic [DW-1:0] BLANK   = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    pic_frame_loader_if.slave bus,
    output logic          loaded,
    output logic          load_done,
    output logic          sync_err,
    output logic [AW-1:0] wr_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(PIX_NUM - 1);
    localparam logic [AW-1:0] FULL_CNT  = AW'(PIX_NUM);
    localparam logic [31:0]   NUM32     = 32'(PIX_NUM);

    state_t        state;
    logic [DW-1:0] mem [PIX_NUM];
    logic          accept;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    // An sof byte always lands at address 0, whatever state we are in.
    assign accept  = bus.in_valid && bus.in_ready;
    assign wr_en   = accept && (bus.in_sof || (state == LOAD));
    assign wr_addr = bus.in_sof ? '0 : wr_cnt;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.in_data;
        end
    end

    // Read-first: a same-cycle write to rd_addr is not visible until next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data <= BLANK;
        end else if (loaded && (32'(bus.rd_addr) < NUM32)) begin
            bus.rd_data <= mem[bus.rd_addr];
        end else begin
            bus.rd_data <= BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            loaded       <= 1'b0;
            load_done    <= 1'b0;
            sync_err     <= 1'b0;
            wr_cnt       <= '0;
        end else begin
            bus.in_ready <= 1'b1;
            load_done    <= 1'b0;
            sync_err     <= 1'b0;
            if (accept) begin
                if (bus.in_sof) begin
                    sync_err <= (state == LOAD);
                    if (PIX_NUM == 1) begin
                        state     <= DONE;
                        loaded    <= 1'b1;
                        load_done <= 1'b1;
                        wr_cnt    <= FULL_CNT;
                    end else begin
                        state  <= LOAD;
                        loaded <= 1'b0;
                        wr_cnt <= AW'(1);
                    end
                end else if (state == LOAD) begin
                    if (wr_cnt == LAST_ADDR) begin
                        state     <= DONE;
                        loaded    <= 1'b1;
                        load_done <= 1'b1;
                        wr_cnt    <= FULL_CNT;
                    end else begin
                        wr_cnt <= wr_cnt + AW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pic_frame_loader.sv
// Directed bench for pic_frame_loader: full loads, gapped load, sof abort,
// out-of-range reads and reset during a reload.
module tb_pic_frame_loader;

    localparam int AW      = 16;
    localparam int DW      = 8;
    localparam int PIX_NUM = 39600;

    logic          clk;
    logic          rst;
    logic          loaded;
    logic          load_done;
    logic          sync_err;
    logic [AW-1:0] wr_cnt;

    int passCount;
    int totalCount;
    int doneCount;
    int syncCount;

    pic_frame_loader_if #(.AW(AW), .DW(DW)) bus ();

    pic_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .loaded    (loaded),
        .load_done (load_done),
        .sync_err  (sync_err),
        .wr_cnt    (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sample between active edges so each pulse counts once.
    always @(negedge clk) begin
        if (load_done === 1'b1) doneCount++;
        if (sync_err === 1'b1) syncCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic valid, input logic sof);
        bus.in_data  = data;
        bus.in_valid = valid;
        bus.in_sof   = sof;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic readCheck(input string tag, input logic [AW-1:0] addr, input logic [7:0] expected);
        bus.rd_addr = addr;
        tick();
        checkOutput(tag, 32'(bus.rd_data), 32'(expected));
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        doneCount  = 0;
        syncCount  = 0;
        rst        = 1'b1;
        bus.rd_addr = '0;
        applyStimulus(8'h00, 1'b0, 1'b0);

        repeat (3) tick();
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_loaded", 32'(loaded), 32'd0);
        checkOutput("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        checkOutput("rst_rd_data", 32'(bus.rd_data), 32'h00);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_sync_err", 32'(sync_err), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        for (int a = 0; a < 6; a++) begin
            readCheck("blank_read_unloaded", AW'(a), 8'h00);
        end

        // Non-sof bytes in IDLE must be dropped.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h55, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("idle_discard_wr_cnt", 32'(wr_cnt), 32'd0);
        checkOutput("idle_discard_loaded", 32'(loaded), 32'd0);

        // Continuous full frame, byte i = i[7:0].
        doneCount = 0;
        for (int i = 0; i < PIX_NUM; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            applyStimulus(iv[7:0], 1'b1, i == 0);
            tick();
            if (i == 0) checkOutput("first_wr_cnt", 32'(wr_cnt), 32'd1);
            if (i == 1000) checkOutput("mid_wr_cnt", 32'(wr_cnt), 32'd1001);
            if (i == PIX_NUM - 2) checkOutput("no_early_done", 32'(load_done), 32'd0);
            if (i == PIX_NUM - 1) checkOutput("load_done_pulse", 32'(load_done), 32'd1);
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("load_done_cleared", 32'(load_done), 32'd0);
        checkOutput("load_done_once", 32'(doneCount), 32'd1);
        checkOutput("loaded_after_frame", 32'(loaded), 32'd1);
        checkOutput("wr_cnt_full", 32'(wr_cnt), 32'd39600);
        readCheck("read_0", 16'd0, 8'h00);
        readCheck("read_255", 16'd255, 8'hFF);
        readCheck("read_256", 16'd256, 8'h00);
        readCheck("read_39599", 16'd39599, 8'hAF);
        readCheck("read_39600_oob", 16'd39600, 8'h00);
        readCheck("read_65535_oob", 16'd65535, 8'h00);
        readCheck("read_1234", 16'd1234, 8'hD2);

        // New sof: rd_data for this edge still sees loaded=1, then blanks.
        bus.rd_addr = 16'd255;
        tick();
        syncCount = 0;
        doneCount = 0;
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("loaded_falls_on_sof", 32'(loaded), 32'd0);
        checkOutput("read_same_cycle_loaded", 32'(bus.rd_data), 32'hFF);
        for (int i = 1; i < 100; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b0);
            tick();
            if (i == 1) checkOutput("read_blank_after_sof", 32'(bus.rd_data), 32'h00);
        end
        checkOutput("cut_wr_cnt", 32'(wr_cnt), 32'd100);
        checkOutput("no_sync_err_yet", 32'(syncCount), 32'd0);

        applyStimulus(8'hA5, 1'b1, 1'b1);
        tick();
        checkOutput("sync_err_pulse", 32'(sync_err), 32'd1);
        checkOutput("restart_wr_cnt", 32'(wr_cnt), 32'd1);

        // Complete the restarted frame with idle gaps early on.
        for (int i = 1; i < PIX_NUM; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            if ((i < 3000) && ($urandom_range(0, 9) < 3)) begin
                applyStimulus(8'hEE, 1'b0, 1'b0);
                tick();
                checkOutput("gap_holds_wr_cnt", 32'(wr_cnt), iv);
            end
            applyStimulus(iv[7:0], 1'b1, 1'b0);
            tick();
            if (i == 1) checkOutput("sync_err_cleared", 32'(sync_err), 32'd0);
            if (i == PIX_NUM - 1) checkOutput("gapped_load_done", 32'(load_done), 32'd1);
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("gapped_done_once", 32'(doneCount), 32'd1);
        checkOutput("sync_err_once", 32'(syncCount), 32'd1);
        checkOutput("gapped_loaded", 32'(loaded), 32'd1);
        checkOutput("gapped_wr_cnt", 32'(wr_cnt), 32'd39600);
        readCheck("gapped_read_0", 16'd0, 8'hA5);
        readCheck("gapped_read_255", 16'd255, 8'hFF);
        readCheck("gapped_read_256", 16'd256, 8'h00);
        readCheck("gapped_read_39599", 16'd39599, 8'hAF);

        // Non-sof bytes in DONE are ignored.
        applyStimulus(8'h11, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("done_discard_wr_cnt", 32'(wr_cnt), 32'd39600);
        readCheck("done_discard_read_0", 16'd0, 8'hA5);

        // Reload interrupted by reset at pixel 5000.
        for (int i = 0; i < 5000; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            applyStimulus(iv[7:0] ^ 8'h3C, 1'b1, i == 0);
            tick();
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("reload_wr_cnt", 32'(wr_cnt), 32'd5000);
        checkOutput("reload_loaded", 32'(loaded), 32'd0);
        rst = 1'b1;
        tick();
        checkOutput("midload_rst_wr_cnt", 32'(wr_cnt), 32'd0);
        checkOutput("midload_rst_loaded", 32'(loaded), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("midload_rst_in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(8'h77, 1'b1, 1'b1);
        tick();
        checkOutput("fresh_sof_wr_cnt", 32'(wr_cnt), 32'd1);
        applyStimulus(8'h78, 1'b1, 1'b0);
        tick();
        checkOutput("fresh_second_wr_cnt", 32'(wr_cnt), 32'd2);
        checkOutput("fresh_no_sync_err", 32'(sync_err), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        readCheck("partial_not_exposed", 16'd0, 8'h00);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
